// File: rtl/db15_joy_tx.sv
`default_nettype none
// ============================================================================
//  Module      : db15_joy_cond
//  Description : Conditions one asynchronous host control pin. A flop chain
//                synchronises the pin, then a window filter only accepts a
//                new level once the newest FILTER_LEN synchronised samples
//                all agree on it. The filtered level and its one-cycle-delayed
//                copy are exported so the caller can pick the edge it needs.
//  Ports       : clk       - system clock
//                reset     - synchronous, active-high
//                i_pin     - raw asynchronous pin
//                o_level   - filtered level
//                o_level_d - filtered level delayed by one clk
//  Revision    : 1.0 - initial release
// ============================================================================
module db15_joy_cond #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_level_d
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_all_hi;
    logic                   w_all_lo;
    logic                   r_level;
    logic                   r_level_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // The filter window always includes the current synchroniser output, so
    // only FILTER_LEN-1 older samples need storage. This keeps the pin to
    // filtered-level latency at SYNC_STAGES + FILTER_LEN cycles.
    generate
        if (FILTER_LEN == 1) begin : g_filt_single
            assign w_all_hi = w_sync;
            assign w_all_lo = ~w_sync;
        end else begin : g_filt_window
            logic [FILTER_LEN-2:0] r_hist;
            logic [FILTER_LEN-1:0] w_win;

            assign w_win = {r_hist, w_sync};

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hist <= {(FILTER_LEN-1){RESET_LEVEL}};
                end else begin
                    r_hist <= w_win[FILTER_LEN-2:0];
                end
            end

            assign w_all_hi = &w_win;
            assign w_all_lo = ~|w_win;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level   <= RESET_LEVEL;
            r_level_d <= RESET_LEVEL;
        end else begin
            if (w_all_hi) begin
                r_level <= 1'b1;
            end else if (w_all_lo) begin
                r_level <= 1'b0;
            end
            r_level_d <= r_level;
        end
    end

    assign o_level   = r_level;
    assign o_level_d = r_level_d;

endmodule

// ============================================================================
//  Module      : db15_joy_tx
//  Description : Target side of the DB15 serial joystick link. Behaves like a
//                chain of parallel-in/serial-out shift registers holding
//                {~joy_2, ~joy_1}; the host loads with joy_load low and
//                shifts one bit out per joy_clk rising edge, LSB first.
//  Ports       : clk         - system clock (40-50 MHz)
//                reset       - synchronous, active-high
//                joy_1       - player 1 buttons, active-high, bit0 = R
//                joy_2       - player 2 buttons, active-high
//                joy_clk     - host shift clock, asynchronous
//                joy_load    - host load, asynchronous, low = parallel load
//                joy_data    - serial data, active-low buttons, idle 1
//                frame_done  - one-clk pulse when the last bit is shifted past
//                bit_index   - shifts since the last load, saturating
//                host_active - high while loads keep arriving in time
//  Revision    : 1.0 - initial release
// ============================================================================
module db15_joy_tx #(
    parameter int BITS_PER_PLAYER = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int FILTER_LEN      = 2,
    parameter int TIMEOUT_CYCLES  = 4800000
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [BITS_PER_PLAYER-1:0]             joy_1,
    input  logic [BITS_PER_PLAYER-1:0]             joy_2,
    input  logic                                   joy_clk,
    input  logic                                   joy_load,
    output logic                                   joy_data,
    output logic                                   frame_done,
    output logic [$clog2(2*BITS_PER_PLAYER+1)-1:0] bit_index,
    output logic                                   host_active
);

    localparam int FRAME_LEN = 2 * BITS_PER_PLAYER;
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] c_IDX_FULL = IDX_W'(FRAME_LEN);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    // IDLE exists so that stray joy_clk edges after reset cannot shift
    // anything: shifting is only armed once a fresh load has been seen.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic                 w_load_lvl;
    logic                 w_load_lvl_d;
    logic                 w_clk_lvl;
    logic                 w_clk_lvl_d;
    logic                 w_load_fall;
    logic                 w_clk_rise;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_do_load;
    logic                 w_do_shift;

    logic [FRAME_LEN-1:0] r_shift;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_done;
    logic [CNT_W-1:0]     r_to_cnt;

    // ------------------------------------------------------------------------
    // Input conditioning. Load idles high and clock idles low, so reset the
    // conditioners to those levels; the first real host edge is then seen.
    // ------------------------------------------------------------------------
    db15_joy_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .RESET_LEVEL (1'b1)
    ) u_cond_load (
        .clk       (clk),
        .reset     (reset),
        .i_pin     (joy_load),
        .o_level   (w_load_lvl),
        .o_level_d (w_load_lvl_d)
    );

    db15_joy_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .RESET_LEVEL (1'b0)
    ) u_cond_clk (
        .clk       (clk),
        .reset     (reset),
        .i_pin     (joy_clk),
        .o_level   (w_clk_lvl),
        .o_level_d (w_clk_lvl_d)
    );

    assign w_load_fall = w_load_lvl_d & ~w_load_lvl;
    assign w_clk_rise  = w_clk_lvl & ~w_clk_lvl_d;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_load   = 1'b0;
        w_do_shift  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_load_lvl) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_load_lvl) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!w_load_lvl) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Load is level-driven and takes priority over a clock edge seen in
        // the same cycle. A shift may already happen in the first cycle after
        // load release, while the state register still reads LOAD.
        if (!w_load_lvl) begin
            w_do_load = 1'b1;
        end else if (w_clk_rise && (r_state != ST_IDLE)) begin
            w_do_shift = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Shift register and bit counter. Inputs are only sampled while loading,
    // so the last load cycle's buttons are what get serialised.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '1;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_do_load) begin
                r_shift <= {~joy_2, ~joy_1};
                r_idx   <= '0;
            end else if (w_do_shift) begin
                // Ones fill from the top, so the line idles high once the
                // frame has been fully shifted out.
                r_shift <= {1'b1, r_shift[FRAME_LEN-1:1]};
                if (r_idx != c_IDX_FULL) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (r_idx == c_IDX_LAST) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Host activity timeout. Starting saturated means a freshly reset block
    // reports no host until the first load arrives.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= c_CNT_MAX;
        end else if (w_load_fall) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_CNT_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign joy_data    = r_shift[0];
    assign frame_done  = r_done;
    assign bit_index   = r_idx;
    assign host_active = (r_to_cnt != c_CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_db15_joy_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_db15_joy_tx
//  Description : Self-checking bench for db15_joy_tx. Hand-written vector
//                table, randomized frames against a frame-level model, and
//                directed sequences for latency, glitch, abort, simultaneity,
//                reset and host timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_db15_joy_tx;

    localparam int BPP   = 12;
    localparam int FLEN  = 2 * BPP;
    localparam int TOUT  = 100;

    logic            clk;
    logic            reset;
    logic [BPP-1:0]  joy_1;
    logic [BPP-1:0]  joy_2;
    logic            joy_clk;
    logic            joy_load;
    logic            joy_data;
    logic            frame_done;
    logic [4:0]      bit_index;
    logic            host_active;

    db15_joy_tx #(
        .BITS_PER_PLAYER (BPP),
        .SYNC_STAGES     (2),
        .FILTER_LEN      (2),
        .TIMEOUT_CYCLES  (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .joy_1       (joy_1),
        .joy_2       (joy_2),
        .joy_clk     (joy_clk),
        .joy_load    (joy_load),
        .joy_data    (joy_data),
        .frame_done  (frame_done),
        .bit_index   (bit_index),
        .host_active (host_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_bad;
    int done_seen;

    // Frame-level reference: the frame is the button word captured at load,
    // and bit n of it is on the line after n accepted clocks.
    logic [FLEN-1:0] m_frame;
    int              m_idx;
    int              m_done;
    bit              m_armed;

    typedef struct {
        logic [BPP-1:0] j1;
        logic [BPP-1:0] j2;
        int             nclk;
        logic           exp_data;
        int             exp_idx;
        int             exp_done;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (frame_done === 1'b1) done_seen++;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    function automatic logic m_data();
        return (m_idx < FLEN) ? m_frame[m_idx] : 1'b1;
    endfunction

    task automatic model_reset();
        m_frame   = '1;
        m_idx     = 0;
        m_done    = 0;
        m_armed   = 1'b0;
        done_seen = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        joy_load = 1'b1;
        joy_clk  = 1'b0;
        hold(3);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_load(input logic [BPP-1:0] j1, input logic [BPP-1:0] j2);
        joy_1    = j1;
        joy_2    = j2;
        joy_load = 1'b0;
        hold(8);
        joy_load = 1'b1;
        hold(8);
        m_frame = {~j2, ~j1};
        m_idx   = 0;
        m_armed = 1'b1;
    endtask

    task automatic pulse_clk();
        joy_clk = 1'b1;
        hold(8);
        joy_clk = 1'b0;
        hold(8);
        if (m_armed && m_idx < FLEN) begin
            m_idx++;
            if (m_idx == FLEN) m_done++;
        end
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FLEN-1:0] exp_seq;
        int              d0;
        int              first_hi;
        int              hi_cnt;
        logic [4:0]      idx_before;
        logic            data_before;

        n_total   = 0;
        n_bad     = 0;
        done_seen = 0;
        joy_1     = '0;
        joy_2     = '0;
        reset     = 1'b1;
        joy_load  = 1'b1;
        joy_clk   = 1'b0;

        vecs[0]  = '{12'h005, 12'h800,  0, 1'b0,  0, 0};
        vecs[1]  = '{12'h005, 12'h800,  1, 1'b1,  1, 0};
        vecs[2]  = '{12'h005, 12'h800,  2, 1'b0,  2, 0};
        vecs[3]  = '{12'h005, 12'h800, 23, 1'b0, 23, 0};
        vecs[4]  = '{12'h005, 12'h800, 24, 1'b1, 24, 1};
        vecs[5]  = '{12'h000, 12'h000, 30, 1'b1, 24, 1};
        vecs[6]  = '{12'hFFF, 12'h000,  5, 1'b0,  5, 0};
        vecs[7]  = '{12'h000, 12'hFFF, 12, 1'b0, 12, 0};
        vecs[8]  = '{12'h000, 12'hFFF, 11, 1'b1, 11, 0};
        vecs[9]  = '{12'h800, 12'h000, 11, 1'b0, 11, 0};
        vecs[10] = '{12'hA5A, 12'h5A5,  4, 1'b0,  4, 0};
        vecs[11] = '{12'h0FE, 12'h000,  0, 1'b1,  0, 0};

        // ---------------- reset and idle ----------------
        do_reset();
        hold(20);
        check("rst_data", joy_data, 1'b1);
        check("rst_idx", bit_index, 5'd0);
        check("rst_active", host_active, 1'b0);
        check("rst_done", done_seen, 0);

        // ---------------- full frame sequence ----------------
        exp_seq = 24'h7FFFFA;
        pulse_load(12'h005, 12'h800);
        d0 = done_seen;
        for (int i = 0; i < FLEN; i++) begin
            check($sformatf("seq_bit%0d", i), joy_data, exp_seq[i]);
            pulse_clk();
        end
        check("seq_tail_data", joy_data, 1'b1);
        check("seq_idx", bit_index, 5'd24);
        check("seq_done", done_seen - d0, 1);

        // ---------------- vector table ----------------
        for (int v = 0; v < 12; v++) begin
            pulse_load(vecs[v].j1, vecs[v].j2);
            d0 = done_seen;
            for (int k = 0; k < vecs[v].nclk; k++) pulse_clk();
            check($sformatf("vec%0d_data", v), joy_data, vecs[v].exp_data);
            check($sformatf("vec%0d_idx", v), bit_index, vecs[v].exp_idx);
            check($sformatf("vec%0d_done", v), done_seen - d0, vecs[v].exp_done);
        end

        // ---------------- load latency ----------------
        pulse_load(12'h000, 12'h000);
        for (int k = 0; k < FLEN; k++) pulse_clk();
        joy_1    = 12'h001;
        joy_load = 1'b0;
        hold(4);
        check("lat_before_data", joy_data, 1'b1);
        check("lat_before_idx", bit_index, 5'd24);
        hold(1);
        check("lat_at5_data", joy_data, 1'b0);
        check("lat_at5_idx", bit_index, 5'd0);
        hold(3);
        joy_load = 1'b1;
        hold(8);
        m_frame = {~joy_2, ~joy_1};
        m_idx   = 0;

        // ---------------- one-cycle load glitch ----------------
        pulse_load(12'h0AA, 12'h000);
        for (int k = 0; k < 3; k++) pulse_clk();
        idx_before  = bit_index;
        data_before = joy_data;
        joy_1    = 12'hFFF;
        joy_load = 1'b0;
        tick();
        joy_load = 1'b1;
        hold(10);
        check("glitch_idx", bit_index, 5'd3);
        check("glitch_data", joy_data, 1'b0);
        check("glitch_same", {bit_index, joy_data}, {idx_before, data_before});

        // ---------------- abort mid-frame ----------------
        pulse_load(12'h005, 12'h800);
        for (int k = 0; k < 10; k++) pulse_clk();
        d0 = done_seen;
        pulse_load(12'h003, 12'h000);
        check("abort_idx", bit_index, 5'd0);
        check("abort_data", joy_data, 1'b0);
        check("abort_done", done_seen - d0, 0);

        // ---------------- load fall coincident with clk rise ----------------
        pulse_load(12'h000, 12'h000);
        for (int k = 0; k < 5; k++) pulse_clk();
        joy_1    = 12'h001;
        joy_load = 1'b0;
        joy_clk  = 1'b1;
        hold(8);
        joy_load = 1'b1;
        hold(8);
        joy_clk = 1'b0;
        hold(8);
        m_frame = {~joy_2, ~joy_1};
        m_idx   = 0;
        check("simul_idx", bit_index, 5'd0);
        check("simul_data", joy_data, 1'b0);

        // ---------------- randomized frames against the model ----------------
        for (int it = 0; it < 20; it++) begin
            int n;
            pulse_load(BPP'($urandom), BPP'($urandom));
            // Button changes while shifting must not reach the frame.
            joy_1 = BPP'($urandom);
            joy_2 = BPP'($urandom);
            n = $urandom_range(0, 27);
            for (int k = 0; k < n; k++) pulse_clk();
            if (it % 3 == 1) begin
                pulse_load(BPP'($urandom), BPP'($urandom));
                n = $urandom_range(0, 26);
                for (int k = 0; k < n; k++) pulse_clk();
            end
            check($sformatf("rnd%0d_data", it), joy_data, m_data());
            check($sformatf("rnd%0d_idx", it), bit_index, m_idx);
            check($sformatf("rnd%0d_done", it), done_seen, m_done);
        end

        // ---------------- reset mid-frame ----------------
        pulse_load(12'h0F0, 12'h000);
        for (int k = 0; k < 5; k++) pulse_clk();
        reset = 1'b1;
        tick();
        check("rstmid_idx", bit_index, 5'd0);
        check("rstmid_data", joy_data, 1'b1);
        check("rstmid_active", host_active, 1'b0);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) pulse_clk();
        check("rstmid_noshift_idx", bit_index, m_idx);
        check("rstmid_noshift_data", joy_data, m_data());
        check("rstmid_noshift_done", done_seen, 0);

        // ---------------- host timeout ----------------
        do_reset();
        hold(20);
        check("to_idle_active", host_active, 1'b0);
        first_hi = -1;
        hi_cnt   = 0;
        joy_load = 1'b0;
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (host_active === 1'b1) begin
                if (first_hi < 0) first_hi = t;
                hi_cnt++;
            end
            if (t == 8) joy_load = 1'b1;
        end
        check("to_first_hi", first_hi, 5);
        check("to_hi_cycles", hi_cnt, TOUT);
        check("to_expired", host_active, 1'b0);
        joy_load = 1'b0;
        hold(4);
        check("to_relaunch_pre", host_active, 1'b0);
        hold(1);
        check("to_relaunch", host_active, 1'b1);
        joy_load = 1'b1;
        hold(8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/db15_joy_tx.md
Name: db15_joy_tx

Overview:
- Target-side responder for the DB15 serial joystick link; the host end drives load/clock and samples data.
- Emulates a chain of parallel-in/serial-out shift registers, serialising two 12-button player words onto one data line.
- Used in test rigs and loopback cores to drive the DB15 receiver, and to let a core act as a DB15 pad source for another board.

Parameters:
- BITS_PER_PLAYER, 12: buttons per player. Frame length is 2*BITS_PER_PLAYER.
- SYNC_STAGES, 2: synchroniser flops on joy_clk and joy_load. Minimum 2.
- FILTER_LEN, 2: consecutive equal synchronised samples needed to accept a level change. Minimum 1.
- TIMEOUT_CYCLES, 4800000: clk cycles without a load assertion before host_active drops (100 ms at 48 MHz).

Ports:
- clk  in  1  system clock, 40-50 MHz.
- reset  in  1  synchronous, active-high.
- joy_1  in  BITS_PER_PLAYER  player 1 buttons, active-high, bit0 = R.
- joy_2  in  BITS_PER_PLAYER  player 2 buttons, active-high.
- joy_clk  in  1  host shift clock, asynchronous to clk.
- joy_load  in  1  host load, asynchronous to clk. Active-low: low means parallel load.
- joy_data  out  1  serial data, active-low buttons. Idle level is 1.
- frame_done  out  1  one-clk pulse when the last frame bit has been shifted past.
- bit_index  out  $clog2(2*BITS_PER_PLAYER+1)  number of shifts since the last load.
- host_active  out  1  high while load assertions arrive within TIMEOUT_CYCLES.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high.
  - Reset values: joy_data=1, frame_done=0, bit_index=0, host_active=0, shift register all ones.
  - Synchroniser and filter state resets to joy_load=1 and joy_clk=0, so the first real edge is detected correctly.
- Input conditioning (per input):
  - SYNC_STAGES flop chain, then a filter.
  - The filtered level changes only after the last FILTER_LEN synchronised samples all equal the new level.
  - Edges are detected on the filtered level.
  - Pin change to joy_data change takes exactly SYNC_STAGES+FILTER_LEN+1 clk cycles.
- Shift register:
  - Width 2*BITS_PER_PLAYER, word = {~joy_2, ~joy_1}, LSB shifted first.
  - joy_data is always the register's bit0.
- LOAD state (filtered joy_load=0):
  - Register reloads from the live inputs every clk.
  - bit_index=0. joy_clk edges are ignored.
  - Bit 0 (~joy_1[0]) appears on joy_data without any clock.
- SHIFT state (filtered joy_load=1):
  - On each filtered joy_clk rising edge: shift right, insert 1 at the MSB, bit_index+1.
  - bit_index saturates at 2*BITS_PER_PLAYER. After that, joy_data stays 1 no matter how many extra clocks arrive.
  - Falling joy_clk edges do nothing.
- frame_done: pulses for one clk on the shift that makes bit_index reach 2*BITS_PER_PLAYER. It never pulses again until the next load.
- Simultaneous events: a load falling edge and a clk rising edge accepted in the same cycle → load wins. No shift occurs and bit_index=0.
- Partial frame: a new load mid-frame aborts the frame. No frame_done. Reload as above.
- Input stability: joy_1/joy_2 changes during SHIFT do not alter the frame in flight. They are sampled only while in LOAD, and the last LOAD cycle's value is frozen.
- host_active:
  - A timeout counter clears on every filtered load falling edge and counts up otherwise, saturating.
  - host_active=1 from the cycle after a load falling edge until the counter reaches TIMEOUT_CYCLES, then 0.
- Reset mid-frame: all state returns to reset values in the next cycle. Shifting resumes only after a fresh load.

Test Plan:
- Reset and idle: assert reset, then hold joy_load=1 and joy_clk=0 with no edges → joy_data=1, bit_index=0, frame_done never pulses, host_active=0.
- Full frame:
  - Stimulus: joy_1=12'h005, joy_2=12'h800. Pulse load low, then issue 24 joy_clk rising edges, each held ≥8 clk.
  - Sampled sequence on joy_data: bit0=0, bit1=1, bit2=0, bits3-22=1, bit23=0.
  - frame_done pulses once at edge 24. bit_index=24.
- Overclock: 30 clk edges after load with all buttons released → joy_data=1 for all edges, bit_index stays 24, single frame_done.
- Latency and glitch:
  - A joy_load low pulse lasting 1 clk is rejected (no reload, bit_index unchanged).
  - A clean load fall moves joy_data to the new bit0 exactly 5 clk later (defaults).
- Abort and simultaneity:
  - After 10 shifts, drop load → bit_index=0, joy_data=~joy_1[0], no frame_done.
  - A load fall coincident with a clk rise yields bit_index=0.
- Timeout: with TIMEOUT_CYCLES=100, one load then silence → host_active=1 for 100 cycles, then 0. A new load re-asserts it.
